// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fetch_state_e;

    typedef enum logic [1:0] {
        BR_NONE   = 2'b00,
        BR_EQ     = 2'b01,
        BR_NE     = 2'b10,
        BR_ALWAYS = 2'b11
    } br_type_e;

    localparam int LUT_DEPTH = 32;
    localparam int LUT_W     = 8;

    // Default signed branch offsets, two's complement, entry 0 first.
    localparam logic [LUT_W-1:0] BR_OFFSET_LUT [LUT_DEPTH] = '{
        8'h02, 8'h04, 8'h08, 8'h10,
        8'hFC, 8'hFD, 8'hFE, 8'hFF,
        8'h7F, 8'h80, 8'h20, 8'hE0,
        8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h00, 8'h00,
        8'h00, 8'h00, 8'h00, 8'h00
    };

    // Indices beyond the stored table read as a zero offset.
    function automatic logic [LUT_W-1:0] lut_entry(input int unsigned idx);
        logic [LUT_W-1:0] val;
        val = '0;
        if (idx < LUT_DEPTH) begin
            val = BR_OFFSET_LUT[idx[4:0]];
        end
        return val;
    endfunction

endpackage

// File: rtl/branch_lut.sv
// Combinational ROM mapping a branch index to a signed DW-bit offset.
module branch_lut
    import fetch_pkg::*;
#(
    parameter int LW = 5,
    parameter int DW = 8
) (
    input  logic [LW-1:0]        idx,
    output logic signed [DW-1:0] offset
);

    logic signed [LUT_W-1:0] raw;

    // Look up the stored entry and sign-extend or trim it to the datapath width.
    always_comb begin
        raw    = $signed(lut_entry(int'(idx)));
        offset = DW'(raw);
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch controller: IDLE/RUN/DONE sequencing, program counter and retired-instruction count.
// Control interface: Start is a one-cycle request honoured only in IDLE or DONE;
// Stall freezes all state in RUN and overrides Halt and branches; Halt overrides branches.
module fetch_ctrl
    import fetch_pkg::*;
#(
    parameter int PW = 10,
    parameter int LW = 5,
    parameter int DW = 8
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          Start,
    input  logic [PW-1:0] StartAddr,
    input  logic          Stall,
    input  logic          Halt,
    input  logic [1:0]    BrType,
    input  logic [LW-1:0] BrIdx,
    input  logic          isEqual,
    output logic [PW-1:0] PC,
    output logic          BrTaken,
    output logic          Done,
    output logic [15:0]   InstCnt,
    output fetch_state_e  FsmState
);

    logic signed [DW-1:0] br_off;
    logic [PW-1:0]        br_off_ext;
    logic [PW-1:0]        pc_next;
    logic                 advance;
    logic                 cond;

    branch_lut #(.LW(LW), .DW(DW)) u_lut (
        .idx    (BrIdx),
        .offset (br_off)
    );

    // Branch decision and next sequential/redirected PC for the current cycle.
    always_comb begin
        advance = (FsmState == ST_RUN) && !Stall && !Halt;
        cond    = 1'b0;
        case (BrType)
            BR_EQ:     cond = isEqual;
            BR_NE:     cond = !isEqual;
            BR_ALWAYS: cond = 1'b1;
            default:   cond = 1'b0;
        endcase
        BrTaken    = advance && cond;
        br_off_ext = PW'(br_off);
        pc_next    = BrTaken ? (PC + br_off_ext) : (PC + PW'(1));
    end

    // FSM with PC register and saturating retired-instruction counter.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            FsmState <= ST_IDLE;
            PC       <= '0;
            Done     <= 1'b0;
            InstCnt  <= '0;
        end else begin
            case (FsmState)
                ST_IDLE: begin
                    if (Start) begin
                        PC       <= StartAddr;
                        InstCnt  <= '0;
                        FsmState <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (!Stall) begin
                        if (Halt) begin
                            FsmState <= ST_DONE;
                            Done     <= 1'b1;
                        end else begin
                            PC <= pc_next;
                            if (InstCnt != 16'hFFFF) begin
                                InstCnt <= InstCnt + 16'd1;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (Start) begin
                        PC       <= StartAddr;
                        InstCnt  <= '0;
                        Done     <= 1'b0;
                        FsmState <= ST_RUN;
                    end
                end
                default: begin
                    FsmState <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl with an expected-value queue and a decoupled monitor.
module tb_fetch_ctrl;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic        Clk;
    logic        Reset_n;
    logic        Start;
    logic [9:0]  StartAddr;
    logic        Stall;
    logic        Halt;
    logic [1:0]  BrType;
    logic [4:0]  BrIdx;
    logic        isEqual;
    logic [9:0]  PC;
    logic        BrTaken;
    logic        Done;
    logic [15:0] InstCnt;
    logic [1:0]  state_dbg;

    // {chk_br, br, pc[9:0], done, cnt[15:0], state[1:0]}
    logic [30:0] exp_q[$];
    string       name_q[$];

    int n_vec = 0;
    int n_err = 0;

    fetch_ctrl #(.PW(10), .LW(5), .DW(8)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .Start     (Start),
        .StartAddr (StartAddr),
        .Stall     (Stall),
        .Halt      (Halt),
        .BrType    (BrType),
        .BrIdx     (BrIdx),
        .isEqual   (isEqual),
        .PC        (PC),
        .BrTaken   (BrTaken),
        .Done      (Done),
        .InstCnt   (InstCnt),
        .FsmState  (state_dbg)
    );

    // Clock
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string nm, input string fld, input logic [15:0] act, input logic [15:0] exp);
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s.%s: got %0h expected %0h", nm, fld, act, exp);
        end
    endtask

    // Driver: apply one vector at the falling edge and queue what it must produce.
    task automatic step(
        input logic rst, input logic st, input logic [9:0] addr,
        input logic stl, input logic hlt, input logic [1:0] bt,
        input logic [4:0] bi, input logic eq,
        input logic cbr, input logic ebr, input logic [9:0] epc,
        input logic edone, input logic [15:0] ecnt, input logic [1:0] est,
        input string nm);
        @(negedge Clk);
        Reset_n   = rst;
        Start     = st;
        StartAddr = addr;
        Stall     = stl;
        Halt      = hlt;
        BrType    = bt;
        BrIdx     = bi;
        isEqual   = eq;
        exp_q.push_back({cbr, ebr, epc, edone, ecnt, est});
        name_q.push_back(nm);
    endtask

    // Monitor: BrTaken checked before the edge, registered outputs after it.
    initial begin
        logic [30:0] e;
        string nm;
        forever begin
            @(negedge Clk);
            #1;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                n_vec++;
                if (e[30]) chk(nm, "BrTaken", {15'd0, BrTaken}, {15'd0, e[29]});
                @(posedge Clk);
                #1;
                chk(nm, "PC",      {6'd0, PC},         {6'd0, e[28:19]});
                chk(nm, "Done",    {15'd0, Done},      {15'd0, e[18]});
                chk(nm, "InstCnt", InstCnt,            e[17:2]);
                chk(nm, "State",   {14'd0, state_dbg}, {14'd0, e[1:0]});
            end
        end
    end

    initial begin
        Reset_n = 1'b0; Start = 1'b0; StartAddr = '0; Stall = 1'b0;
        Halt = 1'b0; BrType = 2'b00; BrIdx = '0; isEqual = 1'b0;

        //    rst st addr    stl hlt bt     bi     eq    cbr br  pc      dn  cnt    state
        step(0, 0, 10'h000, 0, 0, 2'd0, 5'd0, 0,   0, 0, 10'h000, 0, 16'd0, S_IDLE, "reset");
        step(0, 1, 10'h2AA, 1, 1, 2'd0, 5'd0, 0,   1, 0, 10'h000, 0, 16'd0, S_IDLE, "reset_overrides");
        step(1, 0, 10'h2AA, 0, 0, 2'd3, 5'd0, 0,   1, 0, 10'h000, 0, 16'd0, S_IDLE, "idle_hold");
        step(1, 1, 10'h010, 0, 0, 2'd0, 5'd0, 0,   1, 0, 10'h010, 0, 16'd0, S_RUN,  "start_010");
        step(1, 0, 10'h000, 0, 0, 2'd0, 5'd0, 0,   1, 0, 10'h011, 0, 16'd1, S_RUN,  "seq1");
        step(1, 0, 10'h000, 0, 0, 2'd0, 5'd0, 0,   1, 0, 10'h012, 0, 16'd2, S_RUN,  "seq2");
        step(1, 1, 10'h2AA, 0, 0, 2'd0, 5'd0, 0,   1, 0, 10'h013, 0, 16'd3, S_RUN,  "seq3_start_ignored");
        step(1, 0, 10'h000, 0, 0, 2'd0, 5'd0, 0,   1, 0, 10'h014, 0, 16'd4, S_RUN,  "seq4");
        step(1, 0, 10'h000, 0, 0, 2'd0, 5'd0, 0,   1, 0, 10'h015, 0, 16'd5, S_RUN,  "seq5");
        step(1, 0, 10'h000, 1, 1, 2'd3, 5'd0, 0,   1, 0, 10'h015, 0, 16'd5, S_RUN,  "stall_over_halt");
        step(1, 0, 10'h000, 0, 1, 2'd3, 5'd0, 0,   1, 0, 10'h015, 1, 16'd5, S_DONE, "halt_over_branch");
        step(1, 0, 10'h000, 0, 0, 2'd3, 5'd0, 0,   1, 0, 10'h015, 1, 16'd5, S_DONE, "done_hold");
        step(1, 1, 10'h100, 0, 0, 2'd0, 5'd0, 0,   1, 0, 10'h100, 0, 16'd0, S_RUN,  "restart_100");
        step(1, 0, 10'h000, 0, 1, 2'd0, 5'd0, 0,   1, 0, 10'h100, 1, 16'd0, S_DONE, "halt_100");
        step(1, 1, 10'h020, 0, 0, 2'd0, 5'd0, 0,   1, 0, 10'h020, 0, 16'd0, S_RUN,  "restart_020");
        step(1, 0, 10'h000, 0, 0, 2'd1, 5'd4, 1,   1, 1, 10'h01C, 0, 16'd1, S_RUN,  "beq_taken");
        step(1, 0, 10'h000, 0, 0, 2'd3, 5'd1, 0,   1, 1, 10'h020, 0, 16'd2, S_RUN,  "jmp_plus4");
        step(1, 0, 10'h000, 0, 0, 2'd1, 5'd4, 0,   1, 0, 10'h021, 0, 16'd3, S_RUN,  "beq_not_taken");
        step(1, 0, 10'h000, 0, 0, 2'd2, 5'd4, 0,   1, 1, 10'h01D, 0, 16'd4, S_RUN,  "bne_taken");
        step(1, 0, 10'h000, 0, 0, 2'd2, 5'd4, 1,   1, 0, 10'h01E, 0, 16'd5, S_RUN,  "bne_not_taken");
        step(1, 0, 10'h000, 1, 0, 2'd3, 5'd4, 0,   1, 0, 10'h01E, 0, 16'd5, S_RUN,  "stall_over_branch");
        step(1, 0, 10'h000, 0, 1, 2'd0, 5'd0, 0,   1, 0, 10'h01E, 1, 16'd5, S_DONE, "halt_01E");
        step(1, 1, 10'h3FF, 0, 0, 2'd0, 5'd0, 0,   1, 0, 10'h3FF, 0, 16'd0, S_RUN,  "restart_3FF");
        step(1, 0, 10'h000, 0, 0, 2'd0, 5'd0, 0,   1, 0, 10'h000, 0, 16'd1, S_RUN,  "wrap_up");
        step(1, 0, 10'h000, 0, 0, 2'd0, 5'd0, 0,   1, 0, 10'h001, 0, 16'd2, S_RUN,  "seq_001");
        step(1, 0, 10'h000, 0, 0, 2'd0, 5'd0, 0,   1, 0, 10'h002, 0, 16'd3, S_RUN,  "seq_002");
        step(1, 0, 10'h000, 0, 0, 2'd3, 5'd5, 0,   1, 1, 10'h3FF, 0, 16'd4, S_RUN,  "wrap_down");
        step(1, 0, 10'h000, 0, 1, 2'd0, 5'd0, 0,   1, 0, 10'h3FF, 1, 16'd4, S_DONE, "halt_3FF");
        step(1, 1, 10'h155, 0, 0, 2'd0, 5'd0, 0,   1, 0, 10'h155, 0, 16'd0, S_RUN,  "restart_155");
        step(0, 1, 10'h200, 0, 0, 2'd0, 5'd0, 0,   1, 0, 10'h000, 0, 16'd0, S_IDLE, "reset_mid_run");
        step(1, 0, 10'h000, 0, 0, 2'd0, 5'd0, 0,   1, 0, 10'h000, 0, 16'd0, S_IDLE, "no_resume");
        step(1, 1, 10'h155, 0, 0, 2'd0, 5'd0, 0,   1, 0, 10'h155, 0, 16'd0, S_RUN,  "start_after_reset");
        step(1, 0, 10'h000, 0, 0, 2'd0, 5'd0, 0,   1, 0, 10'h156, 0, 16'd1, S_RUN,  "seq_156");

        // Let the monitor drain its queue, with a bounded wait.
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(posedge Clk);
        end
        @(posedge Clk);
        #3;
        if (exp_q.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d vectors left unchecked, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 SHALL have parameter PW, default 10: program counter width.
REQ-002 SHALL have parameter LW, default 5: branch-offset LUT index width (2^LW entries).
REQ-003 SHALL have parameter DW, default 8: datapath width, matching the execute-stage ALU width.
REQ-004 SHALL have port Clk, input, 1: sole clock; all state updates on its rising edge.
REQ-005 SHALL have port Reset_n, input, 1: reset, synchronous, active-low.
REQ-006 SHALL have port Start, input, 1: begin execution at StartAddr.
REQ-007 SHALL have port StartAddr, input, PW: initial PC loaded on Start.
REQ-008 SHALL have port Stall, input, 1: freeze PC, state and counter for this cycle.
REQ-009 SHALL have port Halt, input, 1: decoded halt instruction at current PC.
REQ-010 SHALL have port BrType, input, 2: 00 none, 01 branch-if-equal, 10 branch-if-not-equal, 11 unconditional.
REQ-011 SHALL have port BrIdx, input, LW: LUT index selecting the signed branch offset.
REQ-012 SHALL have port isEqual, input, 1: ALU compare result (A == C) for the current instruction.
REQ-013 SHALL have port PC, output, PW: address of the current instruction.
REQ-014 SHALL have port BrTaken, output, 1: combinational; branch redirect this cycle.
REQ-015 SHALL have port Done, output, 1: registered; program halted.
REQ-016 SHALL have port InstCnt, output, 16: retired-instruction count.

Function
REQ-017 SHALL implement a three-state FSM: IDLE, RUN, DONE.
REQ-018 IDLE: Start=1 -> PC <= StartAddr, InstCnt <= 0, next state RUN; otherwise all outputs hold.
REQ-019 RUN with Stall=1: PC, state and InstCnt hold; BrTaken=0; Stall takes priority over Halt and branch.
REQ-020 RUN, Stall=0, Halt=1: next state DONE, PC holds, InstCnt unchanged; Halt takes priority over branch.
REQ-021 RUN, Stall=0, Halt=0: BrTaken = (BrType==01 & isEqual) | (BrType==10 & !isEqual) | (BrType==11).
REQ-022 Taken branch: PC <= PC + sign-extended DW-bit LUT offset, modulo 2^PW; not taken: PC <= PC + 1, modulo 2^PW.
REQ-023 Each non-stalled, non-halt RUN cycle increments InstCnt by 1, saturating at 16'hFFFF.
REQ-024 PC wrap-around: PC = 2^PW-1 sequential -> 0; negative offset below 0 wraps to the top of the address space, with no error flag.
REQ-025 Start SHALL be ignored in RUN.
REQ-026 DONE: Done=1; Start=1 -> PC <= StartAddr, InstCnt <= 0, Done <= 0, next state RUN.
REQ-027 Redirect latency SHALL be one cycle: a taken branch's target appears on PC the edge after BrTaken=1.
REQ-028 BrTaken SHALL be 0 outside RUN.

Reset
REQ-029 Reset_n=0 sampled at a rising edge SHALL force IDLE, PC=0, Done=0 and InstCnt=0, overriding Start, Stall and Halt.
REQ-030 Reset asserted mid-RUN SHALL abandon the program; it SHALL not resume until a new Start.

Structure
REQ-031 Package fetch_pkg SHALL hold the FSM state enum, the BrType enum, and the default LUT offset table constant.
REQ-032 Sub-module branch_lut SHALL be a combinational ROM: LW-bit index in, DW-bit signed offset out, contents taken from the fetch_pkg constant.
REQ-033 fetch_ctrl SHALL contain the FSM, PC register and InstCnt counter only.

Verification
REQ-034 Verification SHALL cover sequential run: Start with StartAddr=0x010, 5 cycles with BrType=00 -> PC 0x011..0x015, InstCnt=5.
REQ-035 Verification SHALL cover branch-if-equal: PC=0x020, BrType=01, isEqual=1, LUT offset -4 -> BrTaken=1, next PC=0x01C; same stimulus with isEqual=0 -> next PC=0x021.
REQ-036 Verification SHALL cover priority: Stall=1 and Halt=1 together -> PC and state hold; release Stall with Halt=1 -> Done=1 next cycle with PC unchanged.
REQ-037 Verification SHALL cover wrap: PC=0x3FF with BrType=00 -> next PC=0x000; PC=0x002 with unconditional offset -3 -> next PC=0x3FF.
REQ-038 Verification SHALL cover reset mid-run: Reset_n=0 during RUN at PC=0x155 -> next edge PC=0, IDLE, Done=0, InstCnt=0; Start is then required to resume.
REQ-039 Verification SHALL cover restart from DONE: Start with StartAddr=0x100 -> Done=0, PC=0x100, InstCnt=0, state RUN.
